dds_step_ctrl: RTL and testbench

Frequency-step controller for the DDS phase accumulator. Filters the raw 8-bit frequency switches and sequences run/hold. Commits each new step word only at a phase-wrap boundary, so the ROM address sequence never glitches mid-period. It sits between the board switches and the accumulator. It drives the accumulator's increment (`step`) and a clear pulse, and observes the accumulator's address to detect wraps. An optional linear sweep mode steps the frequency word between a start and a stop value.

---
 rtl/dds_step_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_dds_step_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_step_ctrl.sv
// dds_step_ctrl: frequency-step controller for the DDS phase accumulator.
// It filters the raw frequency switches and sequences run/hold. New step
// words are committed only at a phase-wrap boundary.
// Optional feature: define DDS_SWEEP_EN to compile in the linear sweep mode.
// This adds the SWEEP state, the dwell counter, and the s0/stop compare.
//
// Output contract (there is no valid/ready handshake on this block):
//   step    holds the current increment and changes only on a clock edge.
//   pending is high while a filtered switch value differs from step and is
//           waiting for the next wrap.
//   acc_clr is a registered pulse, exactly one cycle wide.
//   state   exposes the FSM (0 = IDLE, 1 = RUN, 2 = SWEEP) for observation.
module dds_step_ctrl #(
  parameter int STABLE_CYC = 64,
  parameter int DWELL      = 10000
) (
  input  logic       signal,
  input  logic       rst_n,
  input  logic [7:0] k,
  input  logic       run,
  input  logic       sweep,
  input  logic [7:0] stop_k,
  input  logic [7:0] address,
  output logic [7:0] step,
  output logic       acc_clr,
  output logic       pending,
  output logic [1:0] state
);

  localparam int SW = $clog2(STABLE_CYC);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    k_s1, k_sync, k_cand, k_stable;
  logic [SW-1:0] stab_cnt;
  logic [7:0]    addr_q;
  logic [7:0]    next_step;
  logic          run_q;
  logic          run_rise;
  logic          wrap;

`ifdef DDS_SWEEP_EN
  localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);

  logic [7:0]     s0;
  logic [7:0]     stop_q;
  logic [DWW-1:0] dwell_cnt;
  logic           adv_arm;
`else
  // Sweep inputs and the dwell length have no function in this build.
  logic [40:0] unused_cfg;
  assign unused_cfg = {sweep, stop_k, 32'(DWELL)};
`endif

  assign run_rise = run & ~run_q;
  assign wrap     = (address < addr_q);
  assign state    = state_q;

  // Two-flop synchronizer for the asynchronous switch bank.
  always_ff @(posedge signal or negedge rst_n) begin
    if (!rst_n) begin
      k_s1   <= 8'd0;
      k_sync <= 8'd0;
    end else begin
      k_s1   <= k;
      k_sync <= k_s1;
    end
  end

  // Stability filter: accept a candidate only after it has stayed quiet.
  always_ff @(posedge signal or negedge rst_n) begin
    if (!rst_n) begin
      k_cand   <= 8'd0;
      k_stable <= 8'd0;
      stab_cnt <= '0;
    end else if (k_sync != k_cand) begin
      k_cand   <= k_sync;
      stab_cnt <= '0;
    end else if (stab_cnt == STAB_LAST) begin
      k_stable <= k_cand;
    end else begin
      stab_cnt <= stab_cnt + SW'(1);
    end
  end

  // Delayed address for wrap detection, and delayed run for edge detection.
  always_ff @(posedge signal or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= 8'd0;
      run_q  <= 1'b0;
    end else begin
      addr_q <= address;
      run_q  <= run;
    end
  end

  // FSM state register.
  always_ff @(posedge signal or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start on a run rising edge, fall back to IDLE on run low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_rise) begin
`ifdef DDS_SWEEP_EN
          state_d = sweep ? ST_SWEEP : ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        if (!run) state_d = ST_IDLE;
      end
`ifdef DDS_SWEEP_EN
      ST_SWEEP: begin
        if (!run) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Step word, pending flag, clear pulse and sweep bookkeeping.
  always_ff @(posedge signal or negedge rst_n) begin
    if (!rst_n) begin
      step      <= 8'd0;
      next_step <= 8'd0;
      pending   <= 1'b0;
      acc_clr   <= 1'b0;
`ifdef DDS_SWEEP_EN
      s0        <= 8'd0;
      stop_q    <= 8'd0;
      dwell_cnt <= '0;
      adv_arm   <= 1'b0;
`endif
    end else begin
      acc_clr <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          step    <= 8'd0;
          pending <= 1'b0;
          if (run_rise) begin
            step      <= k_stable;
            next_step <= k_stable;
`ifdef DDS_SWEEP_EN
            s0        <= k_stable;
            stop_q    <= stop_k;
            dwell_cnt <= '0;
            adv_arm   <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (!run) begin
            // Run drop wins over any commit due in the same cycle.
            step    <= 8'd0;
            acc_clr <= 1'b1;
            pending <= 1'b0;
          end else begin
            next_step <= k_stable;
            // A zero step stalls the accumulator, so no wrap would ever come.
            if (pending && (wrap || step == 8'd0)) begin
              step    <= next_step;
              pending <= 1'b0;
            end else begin
              pending <= (k_stable != step);
            end
          end
        end
`ifdef DDS_SWEEP_EN
        ST_SWEEP: begin
          if (!run) begin
            step    <= 8'd0;
            acc_clr <= 1'b1;
            pending <= 1'b0;
            adv_arm <= 1'b0;
          end else if (!adv_arm) begin
            if (dwell_cnt == DWELL_LAST) begin
              adv_arm   <= 1'b1;
              dwell_cnt <= '0;
            end else begin
              dwell_cnt <= dwell_cnt + DWW'(1);
            end
          end else if (wrap || step == 8'd0) begin
            adv_arm <= 1'b0;
            if (s0 != stop_q) begin
              if (step == stop_q) begin
                step    <= s0;
                acc_clr <= 1'b1;
              end else if (s0 < stop_q) begin
                step <= step + 8'd1;
              end else begin
                step <= step - 8'd1;
              end
            end
          end
        end
`endif
        default: begin
          step    <= 8'd0;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_step_ctrl.sv
// tb_dds_step_ctrl: directed scoreboard bench for dds_step_ctrl.
// The sweep checks are compiled only when DDS_SWEEP_EN is defined.
module tb_dds_step_ctrl;

  logic       signal = 1'b0;
  logic       rst_n;
  logic [7:0] k;
  logic       run;
  logic       sweep;
  logic [7:0] stop_k;
  logic [7:0] address;
  logic [7:0] step;
  logic       acc_clr;
  logic       pending;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Expected record: {need_wrap, acc_clr, state[1:0], step[7:0]}
  logic [11:0] exp_q[$];

  logic       acc_en;
  logic [7:0] addr_force;

  dds_step_ctrl #(.STABLE_CYC(64), .DWELL(4)) dut (
    .signal (signal),
    .rst_n  (rst_n),
    .k      (k),
    .run    (run),
    .sweep  (sweep),
    .stop_k (stop_k),
    .address(address),
    .step   (step),
    .acc_clr(acc_clr),
    .pending(pending),
    .state  (state)
  );

  // Clock and reset-independent free-running clock.
  always #5 signal = ~signal;

  // Accumulator model: adds step each cycle, or holds a forced address.
  initial begin
    address = 8'd0;
    forever begin
      @(posedge signal);
      #1;
      if (!acc_en)               address = addr_force;
      else if (!run || acc_clr)  address = 8'd0;
      else                       address = address + step;
    end
  end

  // Monitor: every visible output event pops one expectation.
  initial begin
    logic [7:0]  step_last;
    logic [1:0]  state_last;
    logic [7:0]  a_last;
    logic        w_last;
    logic [11:0] e;
    step_last  = 8'd0;
    state_last = 2'd0;
    a_last     = 8'd0;
    w_last     = 1'b0;
    forever begin
      @(negedge signal);
      if (!rst_n) begin
        step_last  = 8'd0;
        state_last = 2'd0;
        w_last     = 1'b0;
        a_last     = address;
      end else begin
        if (step != step_last || acc_clr || state != state_last) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got clr=%0b state=%0d step=%0h want no event",
                     acc_clr, state, step);
          end else begin
            e = exp_q.pop_front();
            if ({acc_clr, state, step} !== e[10:0]) begin
              errors++;
              $display("FAIL event got clr=%0b state=%0d step=%0h want clr=%0b state=%0d step=%0h",
                       acc_clr, state, step, e[10], e[9:8], e[7:0]);
            end else if (e[11] && !w_last) begin
              errors++;
              $display("FAIL wrap_align step=%0h got wrap=0 want wrap=1", step);
            end
          end
        end
        step_last  = step;
        state_last = state;
        w_last     = (address < a_last);
        a_last     = address;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge signal);
    #2;
  endtask

  task automatic expect_ev(input logic need_wrap, input logic clr,
                           input logic [1:0] st, input logic [7:0] s);
    exp_q.push_back({need_wrap, clr, st, s});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge signal);
      n++;
    end while (exp_q.size() != 0 && n < budget);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got remaining=%0d want remaining=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_pending(input string name, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge signal);
      #2;
      n++;
    end while (!pending && n < budget);
    check(name, {31'd0, pending}, 32'd1);
  endtask

  // Main stimulus sequence.
  initial begin
    rst_n = 1'b0; run = 1'b0; sweep = 1'b0; k = 8'd0; stop_k = 8'd0;
    acc_en = 1'b1; addr_force = 8'd0;
    cyc(3);
    check("reset_step",    {24'd0, step},    32'd0);
    check("reset_state",   {30'd0, state},   32'd0);
    check("reset_acc_clr", {31'd0, acc_clr}, 32'd0);
    check("reset_pending", {31'd0, pending}, 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Run start at step 4.
    k = 8'h04;
    cyc(70);
    expect_ev(1'b0, 1'b0, 2'd1, 8'h04);
    run = 1'b1;
    wait_empty("run_start", 10);

    // Wrap-aligned commit of 0x10.
    k = 8'h10;
    expect_ev(1'b1, 1'b0, 2'd1, 8'h10);
    cyc(60);
    check("pending_early", {31'd0, pending}, 32'd0);
    wait_pending("wrap_pending", 20);
    wait_empty("wrap_commit", 200);

    // Switch bounce never settles long enough, then settles at 5.
    for (int i = 0; i < 50; i++) begin
      k = (i % 2 == 0) ? 8'd3 : 8'd5;
      cyc(10);
    end
    check("bounce_pending", {31'd0, pending}, 32'd0);
    k = 8'd5;
    expect_ev(1'b1, 1'b0, 2'd1, 8'd5);
    wait_empty("bounce_settle", 300);

    // Zero step: commit to 0 at a wrap, then 0 -> 1 without a wrap.
    k = 8'd0;
    expect_ev(1'b1, 1'b0, 2'd1, 8'd0);
    wait_empty("to_zero", 300);
    k = 8'd1;
    expect_ev(1'b0, 1'b0, 2'd1, 8'd1);
    wait_empty("zero_commit", 100);

    // Run drop in the same cycle as a wrap with a commit pending.
    acc_en = 1'b0; addr_force = 8'd0;
    cyc(3);
    addr_force = 8'd100;
    cyc(3);
    k = 8'h20;
    wait_pending("drop_pending", 100);
    addr_force = 8'd2;
    cyc(1);
    expect_ev(1'b0, 1'b1, 2'd0, 8'd0);
    run = 1'b0;
    wait_empty("run_drop", 5);
    check("drop_pending_clr", {31'd0, pending}, 32'd0);
    check("drop_state",       {30'd0, state},   32'd0);

    // Restart, then start with sweep requested.
    acc_en = 1'b1;
    cyc(2);
    expect_ev(1'b0, 1'b0, 2'd1, 8'h20);
    run = 1'b1;
    wait_empty("restart", 10);
    expect_ev(1'b0, 1'b1, 2'd0, 8'd0);
    run = 1'b0;
    wait_empty("stop_a", 10);
    stop_k = 8'h20;
    sweep  = 1'b1;
`ifdef DDS_SWEEP_EN
    expect_ev(1'b0, 1'b0, 2'd2, 8'h20);
`else
    expect_ev(1'b0, 1'b0, 2'd1, 8'h20);
`endif
    run = 1'b1;
    wait_empty("sweep_select", 10);
    cyc(20);
    expect_ev(1'b0, 1'b1, 2'd0, 8'd0);
    run = 1'b0;
    wait_empty("stop_b", 10);
    sweep = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    expect_ev(1'b0, 1'b0, 2'd1, 8'h20);
    run = 1'b1;
    wait_empty("pre_reset", 10);
    cyc(5);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_step",    {24'd0, step},    32'd0);
    check("async_state",   {30'd0, state},   32'd0);
    check("async_acc_clr", {31'd0, acc_clr}, 32'd0);
    run = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    check("post_reset_state", {30'd0, state}, 32'd0);
    check("post_reset_step",  {24'd0, step},  32'd0);

`ifdef DDS_SWEEP_EN
    // Sweep 2 -> 4 with reload and clear.
    k = 8'd2; stop_k = 8'd4; sweep = 1'b1;
    cyc(70);
    expect_ev(1'b0, 1'b0, 2'd2, 8'd2);
    expect_ev(1'b1, 1'b0, 2'd2, 8'd3);
    expect_ev(1'b1, 1'b0, 2'd2, 8'd4);
    expect_ev(1'b1, 1'b1, 2'd2, 8'd2);
    run = 1'b1;
    wait_empty("sweep_up", 800);
    expect_ev(1'b0, 1'b1, 2'd0, 8'd0);
    run = 1'b0;
    wait_empty("sweep_up_stop", 10);

    // Sweep 4 -> 2 with reload and clear.
    k = 8'd4; stop_k = 8'd2;
    cyc(70);
    expect_ev(1'b0, 1'b0, 2'd2, 8'd4);
    expect_ev(1'b1, 1'b0, 2'd2, 8'd3);
    expect_ev(1'b1, 1'b0, 2'd2, 8'd2);
    expect_ev(1'b1, 1'b1, 2'd2, 8'd4);
    run = 1'b1;
    wait_empty("sweep_down", 800);
    expect_ev(1'b0, 1'b1, 2'd0, 8'd0);
    run = 1'b0;
    wait_empty("sweep_down_stop", 10);
    sweep = 1'b0;
`endif

    cyc(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
